control_frame_buffer_read_only: RTL and testbench

Read-side pointer controller for the single-page frame buffer. It runs from the same buffer as the write-only controller, which produces page_written_once. The block waits until one full page has been written, then issues one synchronous read address per cycle whenever the downstream HDMI pixel FIFO is not full. It also tags each read with start-of-frame, end-of-line and end-of-frame markers, so the video timing side can align the data.

---
 rtl/control_frame_buffer_read_only.sv | 145 ++++++++++++++
 tb/tb_control_frame_buffer_read_only.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_frame_buffer_read_only.sv
// Read-side pointer controller for the single-page frame buffer: waits for a full page,
// then issues one read per cycle while the pixel FIFO has room, tagged with frame markers.
module control_frame_buffer_read_only #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  input  logic                  page_written_once_i,
  input  logic                  full_i,
  output logic                  rd_o,
  output logic [ADDR_WIDTH-1:0] addr_rd_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  eof_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StWaitPage, StLoad, StRead} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] total_q, total_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           col_q, col_d;
  logic [15:0]           line_q, line_d;
  logic [15:0]           w_q, w_d;
  logic [15:0]           h_q, h_d;
  logic                  rd_q, rd_d;
  logic                  sof_q, sof_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;

  logic [31:0]           prod;
  logic [ADDR_WIDTH-1:0] total_in;
  logic                  geom_zero;
  logic                  last_col;
  logic                  last_pix;

  assign prod      = 32'(resolution_width_i) * 32'(resolution_depth_i);
  assign total_in  = ADDR_WIDTH'(prod - 32'd1);
  assign geom_zero = (resolution_width_i == 16'd0) || (resolution_depth_i == 16'd0);
  assign last_col  = (col_q == w_q - 16'd1);
  assign last_pix  = (ptr_q == total_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    total_d = total_q;
    addr_d  = addr_q;
    col_d   = col_q;
    line_d  = line_q;
    w_d     = w_q;
    h_d     = h_q;
    rd_d    = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    eof_d   = 1'b0;

    case (state_q)
      StWaitPage: begin
        if (page_written_once_i) state_d = StLoad;
      end
      StLoad: begin
        w_d     = resolution_width_i;
        h_d     = resolution_depth_i;
        total_d = total_in;
        ptr_d   = '0;
        col_d   = '0;
        line_d  = '0;
        state_d = geom_zero ? StWaitPage : StRead;
      end
      StRead: begin
        if (!full_i) begin
          rd_d   = 1'b1;
          addr_d = ptr_q;
          sof_d  = (ptr_q == '0);
          eol_d  = last_col;
          eof_d  = last_pix;
          if (last_pix) begin
            ptr_d   = '0;
            col_d   = '0;
            line_d  = '0;
            w_d     = resolution_width_i;
            h_d     = resolution_depth_i;
            total_d = total_in;
            // A zero geometry picked up at the frame wrap cannot be scanned; park until valid.
            if (geom_zero) state_d = StWaitPage;
          end else if (last_col) begin
            ptr_d  = ptr_q + ADDR_WIDTH'(1);
            col_d  = '0;
            line_d = line_q + 16'd1;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            col_d = col_q + 16'd1;
          end
        end
      end
      default: state_d = StWaitPage;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StWaitPage;
      ptr_q   <= '0;
      total_q <= '0;
      addr_q  <= '0;
      col_q   <= '0;
      line_q  <= '0;
      w_q     <= '0;
      h_q     <= '0;
      rd_q    <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      total_q <= total_d;
      addr_q  <= addr_d;
      col_q   <= col_d;
      line_q  <= line_d;
      w_q     <= w_d;
      h_q     <= h_d;
      rd_q    <= rd_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

  // Line count and latched height are kept for observability; the wrap is pointer-driven.
  logic unused_geom;
  assign unused_geom = ^{line_q, h_q};

  assign rd_o      = rd_q;
  assign addr_rd_o = addr_q;
  assign sof_o     = sof_q;
  assign eol_o     = eol_q;
  assign eof_o     = eof_q;
  assign busy_o    = (state_q == StRead);

endmodule

// File: tb/tb_control_frame_buffer_read_only.sv
// Directed bench for control_frame_buffer_read_only; outputs are sampled on the falling edge.
module tb_control_frame_buffer_read_only;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic [15:0] resolution_width_i;
  logic [15:0] resolution_depth_i;
  logic        page_written_once_i;
  logic        full_i;
  logic        rd_o;
  logic [31:0] addr_rd_o;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [35:0] got;
  logic [35:0] exp;

  control_frame_buffer_read_only #(.ADDR_WIDTH(32)) dut (
    .clk_i               (clk_i),
    .resetn_i            (resetn_i),
    .resolution_width_i  (resolution_width_i),
    .resolution_depth_i  (resolution_depth_i),
    .page_written_once_i (page_written_once_i),
    .full_i              (full_i),
    .rd_o                (rd_o),
    .addr_rd_o           (addr_rd_o),
    .sof_o               (sof_o),
    .eol_o               (eol_o),
    .eof_o               (eof_o),
    .busy_o              (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    resetn_i            = 1'b0;
    page_written_once_i = 1'b0;
    full_i              = 1'b0;
    step();
    step();
    resetn_i = 1'b1;
  endtask

  // Page goes high; one cycle in WAIT_PAGE->LOAD, one in LOAD->READ, reads appear after.
  task automatic start();
    page_written_once_i = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    resetn_i            = 1'b0;
    page_written_once_i = 1'b0;
    full_i              = 1'b0;
    resolution_width_i  = 16'd4;
    resolution_depth_i  = 16'd2;
    #3;
    total++;
    got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
    if (got !== 36'd0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %h busy %b want 0 busy 0", got, busy_o);
    end
    step();
    step();
    resetn_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (rd_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_no_page cycle %0d: rd %b busy %b want 0 0", i, rd_o, busy_o);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    resolution_width_i  = 16'd4;
    resolution_depth_i  = 16'd2;
    page_written_once_i = 1'b1;
    step();
    total++;
    if (rd_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL basic_load: rd %b busy %b want 0 0", rd_o, busy_o);
    end
    step();
    total++;
    if (rd_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_enter_read: rd %b busy %b want 0 1", rd_o, busy_o);
    end
    for (int k = 0; k < 9; k++) begin
      int a;
      a = k % 8;
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {1'b1, 1'(a == 0), 1'(a % 4 == 3), 1'(a == 7), 32'(a)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL basic_read %0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_full();
    do_reset();
    resolution_width_i = 16'd4;
    resolution_depth_i = 16'd2;
    start();
    for (int k = 0; k < 5; k++) begin
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {1'b1, 1'(k == 0), 1'(k % 4 == 3), 1'b0, 32'(k)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL full_pre %0d: got %h want %h", k, got, exp);
      end
    end
    full_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {4'b0000, 32'd4};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL full_stall %0d: got %h want %h", i, got, exp);
      end
    end
    full_i = 1'b0;
    for (int k = 5; k < 8; k++) begin
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {1'b1, 1'b0, 1'(k % 4 == 3), 1'(k == 7), 32'(k)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL full_resume %0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_geom_change();
    do_reset();
    resolution_width_i = 16'd4;
    resolution_depth_i = 16'd2;
    start();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 2) resolution_width_i = 16'd2;
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {1'b1, 1'(k == 0), 1'(k % 4 == 3), 1'(k == 7), 32'(k)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL geom_old_frame %0d: got %h want %h", k, got, exp);
      end
    end
    for (int k = 0; k < 5; k++) begin
      int a;
      a = k % 4;
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {1'b1, 1'(a == 0), 1'(a % 2 == 1), 1'(a == 3), 32'(a)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL geom_new_frame %0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_zero_width();
    int n;
    do_reset();
    resolution_width_i  = 16'd0;
    resolution_depth_i  = 16'd480;
    page_written_once_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (rd_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++;
        $display("FAIL zero_w_idle %0d: rd %b busy %b want 0 0", i, rd_o, busy_o);
      end
    end
    resolution_width_i = 16'd640;
    resolution_depth_i = 16'd4;
    n = 0;
    while (rd_o !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    total++;
    if (rd_o !== 1'b1) begin
      bad++;
      $display("FAIL zero_w_start: rd %b want 1 within 8 cycles", rd_o);
    end else begin
      for (int k = 0; k <= 2560; k++) begin
        int a;
        a = k % 2560;
        if (k > 0) step();
        got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
        exp = {1'b1, 1'(a == 0), 1'(a % 640 == 639), 1'(a == 2559), 32'(a)};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL wide_frame %0d: got %h want %h", k, got, exp);
        end
      end
    end
  endtask

  task automatic test_single_pixel();
    do_reset();
    resolution_width_i = 16'd1;
    resolution_depth_i = 16'd1;
    start();
    for (int k = 0; k < 3; k++) begin
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {4'b1111, 32'd0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_pixel %0d: got %h want %h", k, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    resolution_width_i = 16'd4;
    resolution_depth_i = 16'd2;
    start();
    for (int k = 0; k < 5; k++) begin
      step();
      got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
      exp = {1'b1, 1'(k == 0), 1'(k % 4 == 3), 1'b0, 32'(k)};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL mid_pre %0d: got %h want %h", k, got, exp);
      end
    end
    #2;
    resetn_i = 1'b0;
    #1;
    got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
    total++;
    if (got !== 36'd0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_reset: got %h busy %b want 0 busy 0", got, busy_o);
    end
    step();
    resetn_i = 1'b1;
    step();
    step();
    total++;
    if (rd_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reenter: rd %b busy %b want 0 1", rd_o, busy_o);
    end
    step();
    got = {rd_o, sof_o, eol_o, eof_o, addr_rd_o};
    exp = {4'b1100, 32'd0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL mid_restart: got %h want %h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_geom_change();
    test_zero_width();
    test_single_pixel();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
